// File: rtl/park_gate_if.sv
// Gate-side handshake bundle: per-gate entry/exit requests with class bits,
// and the one-cycle grant/deny responses returned to each gate.
interface park_gate_if;
  logic [1:0] ent_req;
  logic [1:0] ent_uni;
  logic [1:0] ext_req;
  logic [1:0] ext_uni;
  logic [1:0] ent_gnt;
  logic [1:0] ent_deny;
  logic [1:0] ext_gnt;
  logic [1:0] ext_deny;

  modport master (
    output ent_req, ent_uni, ext_req, ext_uni,
    input  ent_gnt, ent_deny, ext_gnt, ext_deny
  );

  modport slave (
    input  ent_req, ent_uni, ext_req, ext_uni,
    output ent_gnt, ent_deny, ext_gnt, ext_deny
  );
endinterface

// File: rtl/park_gate_ctrl.sv
// Two-gate entry/exit arbiter with hour-dependent capacity and occupancy counters.
// Define PARK_CTRL_STATS_EN to build the saturating denied-entry counters.
module park_gate_ctrl #(
  parameter int TOTAL_CAP = 700,
  parameter int FREE_BASE = 200,
  parameter int FREE_STEP = 50,
  parameter int FREE_MAX  = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  hour,
  park_gate_if.slave  gate,
  output logic        car_entered,
  output logic        car_exited,
  output logic        is_uni_car_entered,
  output logic        is_uni_car_exited,
  output logic [9:0]  uni_parked_car,
  output logic [9:0]  parked_car,
  output logic [9:0]  uni_vacated_space,
  output logic [9:0]  vacated_space,
  output logic        uni_full,
  output logic        free_full,
  output logic [15:0] deny_cnt_uni,
  output logic [15:0] deny_cnt_free
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t     state, state_nx;
  logic [9:0] free_cap, uni_cap;
  logic       ent_ptr, ext_ptr, ent_ptr_nx, ext_ptr_nx;
  logic       ent_sel, ext_sel, ent_cls, ext_cls, ent_room, ext_has;
  logic [1:0] ent_gnt_nx, ent_deny_nx, ext_gnt_nx, ext_deny_nx;
  logic       car_entered_nx, car_exited_nx, uni_ent_nx, uni_ext_nx;
  logic [9:0] parked_nx, uni_parked_nx;

  always_comb begin
    if (hour >= 5'd8 && hour <= 5'd12)       free_cap = 10'(FREE_BASE);
    else if (hour >= 5'd13 && hour <= 5'd15) free_cap = 10'(FREE_BASE + FREE_STEP * (int'(hour) - 12));
    else                                     free_cap = 10'(FREE_MAX);
  end

  assign uni_cap = 10'(TOTAL_CAP) - free_cap;

  // A shrinking capacity never evicts: vacated space just clamps at zero.
  assign vacated_space     = (free_cap > parked_car)    ? free_cap - parked_car    : 10'd0;
  assign uni_vacated_space = (uni_cap > uni_parked_car) ? uni_cap - uni_parked_car : 10'd0;
  assign free_full         = (vacated_space == 10'd0);
  assign uni_full          = (uni_vacated_space == 10'd0);

  // Round-robin: take the gate the pointer favours, otherwise the other one.
  assign ext_sel  = gate.ext_req[ext_ptr] ? ext_ptr : ~ext_ptr;
  assign ent_sel  = gate.ent_req[ent_ptr] ? ent_ptr : ~ent_ptr;
  assign ext_cls  = gate.ext_uni[ext_sel];
  assign ent_cls  = gate.ent_uni[ent_sel];
  assign ext_has  = ext_cls ? (uni_parked_car != 10'd0) : (parked_car != 10'd0);
  assign ent_room = ent_cls ? !uni_full : !free_full;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx       = state;
    ent_ptr_nx     = ent_ptr;
    ext_ptr_nx     = ext_ptr;
    ent_gnt_nx     = '0;
    ent_deny_nx    = '0;
    ext_gnt_nx     = '0;
    ext_deny_nx    = '0;
    car_entered_nx = 1'b0;
    car_exited_nx  = 1'b0;
    uni_ent_nx     = is_uni_car_entered;
    uni_ext_nx     = is_uni_car_exited;
    parked_nx      = parked_car;
    uni_parked_nx  = uni_parked_car;
    case (state)
      IDLE: begin
        // Exits win over entries because they free space.
        if (|gate.ext_req) begin
          ext_ptr_nx = ~ext_sel;
          if (ext_has) begin
            ext_gnt_nx[ext_sel] = 1'b1;
            car_exited_nx       = 1'b1;
            uni_ext_nx          = ext_cls;
            if (ext_cls) uni_parked_nx = uni_parked_car - 10'd1;
            else         parked_nx     = parked_car - 10'd1;
            state_nx = ISSUE;
          end else begin
            ext_deny_nx[ext_sel] = 1'b1;
            state_nx             = GAP;
          end
        end else if (|gate.ent_req) begin
          ent_ptr_nx = ~ent_sel;
          if (ent_room) begin
            ent_gnt_nx[ent_sel] = 1'b1;
            car_entered_nx      = 1'b1;
            uni_ent_nx          = ent_cls;
            if (ent_cls) uni_parked_nx = uni_parked_car + 10'd1;
            else         parked_nx     = parked_car + 10'd1;
            state_nx = ISSUE;
          end else begin
            ent_deny_nx[ent_sel] = 1'b1;
            state_nx             = GAP;
          end
        end
      end
      ISSUE: state_nx = GAP;
      GAP: begin
        // Requester has dropped its request by now; class flags retire here.
        state_nx   = IDLE;
        uni_ent_nx = 1'b0;
        uni_ext_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      ent_ptr            <= 1'b0;
      ext_ptr            <= 1'b0;
      gate.ent_gnt       <= '0;
      gate.ent_deny      <= '0;
      gate.ext_gnt       <= '0;
      gate.ext_deny      <= '0;
      car_entered        <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_entered <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      parked_car         <= '0;
      uni_parked_car     <= '0;
    end else begin
      state              <= state_nx;
      ent_ptr            <= ent_ptr_nx;
      ext_ptr            <= ext_ptr_nx;
      gate.ent_gnt       <= ent_gnt_nx;
      gate.ent_deny      <= ent_deny_nx;
      gate.ext_gnt       <= ext_gnt_nx;
      gate.ext_deny      <= ext_deny_nx;
      car_entered        <= car_entered_nx;
      car_exited         <= car_exited_nx;
      is_uni_car_entered <= uni_ent_nx;
      is_uni_car_exited  <= uni_ext_nx;
      parked_car         <= parked_nx;
      uni_parked_car     <= uni_parked_nx;
    end
  end

`ifdef PARK_CTRL_STATS_EN
  logic        deny_now;
  logic [15:0] deny_uni_q, deny_free_q;

  assign deny_now = (state == IDLE) && !(|gate.ext_req) && (|gate.ent_req) && !ent_room;

  always_ff @(posedge clk) begin
    if (rst) begin
      deny_uni_q  <= '0;
      deny_free_q <= '0;
    end else if (deny_now) begin
      if (ent_cls && deny_uni_q != 16'hFFFF)   deny_uni_q  <= deny_uni_q + 16'd1;
      if (!ent_cls && deny_free_q != 16'hFFFF) deny_free_q <= deny_free_q + 16'd1;
    end
  end

  assign deny_cnt_uni  = deny_uni_q;
  assign deny_cnt_free = deny_free_q;
`else
  assign deny_cnt_uni  = '0;
  assign deny_cnt_free = '0;
`endif

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Self-checking bench for park_gate_ctrl: directed scenarios plus randomized
// request batches checked against a transaction-level occupancy model.
module tb_park_gate_ctrl;
  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [4:0]  hour = 5'd9;
  logic        car_entered, car_exited, is_uni_car_entered, is_uni_car_exited;
  logic [9:0]  uni_parked_car, parked_car, uni_vacated_space, vacated_space;
  logic        uni_full, free_full;
  logic [15:0] deny_cnt_uni, deny_cnt_free;
  int          n_chk  = 0;
  int          n_fail = 0;

`ifdef PARK_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  park_gate_if gif ();

  park_gate_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .hour              (hour),
    .gate              (gif),
    .car_entered       (car_entered),
    .car_exited        (car_exited),
    .is_uni_car_entered(is_uni_car_entered),
    .is_uni_car_exited (is_uni_car_exited),
    .uni_parked_car    (uni_parked_car),
    .parked_car        (parked_car),
    .uni_vacated_space (uni_vacated_space),
    .vacated_space     (vacated_space),
    .uni_full          (uni_full),
    .free_full         (free_full),
    .deny_cnt_uni      (deny_cnt_uni),
    .deny_cnt_free     (deny_cnt_free)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  function automatic int free_cap_of(input int h);
    if (h >= 8 && h <= 12)  return 200;
    if (h >= 13 && h <= 15) return 200 + 50 * (h - 12);
    return 500;
  endfunction

  // Raise one request at the next falling edge.
  task automatic post(input bit is_ent, input int g, input bit uni);
    @(negedge clk);
    if (is_ent) begin gif.ent_req[g] = 1'b1; gif.ent_uni[g] = uni; end
    else        begin gif.ext_req[g] = 1'b1; gif.ext_uni[g] = uni; end
  endtask

  // Wait up to max_cyc falling edges for a response; drop the answered request.
  // resp = {ent_gnt, ent_deny, ext_gnt, ext_deny}; st = {car_entered, car_exited,
  // is_uni_car_entered, is_uni_car_exited}; hold = class flags at the first edge.
  task automatic await_resp(input int max_cyc, output int lat, output logic [7:0] resp,
                            output logic [3:0] st, output logic [1:0] hold);
    lat  = -1;
    resp = '0;
    st   = '0;
    hold = '0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (i == 1) hold = {is_uni_car_entered, is_uni_car_exited};
      if (|{gif.ent_gnt, gif.ent_deny, gif.ext_gnt, gif.ext_deny}) begin
        lat  = i;
        resp = {gif.ent_gnt, gif.ent_deny, gif.ext_gnt, gif.ext_deny};
        st   = {car_entered, car_exited, is_uni_car_entered, is_uni_car_exited};
        gif.ent_req = gif.ent_req & ~(gif.ent_gnt | gif.ent_deny);
        gif.ext_req = gif.ext_req & ~(gif.ext_gnt | gif.ext_deny);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hour = 5'd9;
    gif.ent_req = '0; gif.ent_uni = '0; gif.ext_req = '0; gif.ext_uni = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (vacated_space !== 10'd200) begin n_fail++; $display("FAIL reset_vacated: got %0d want 200", vacated_space); end
    n_chk++; if (uni_vacated_space !== 10'd500) begin n_fail++; $display("FAIL reset_uni_vacated: got %0d want 500", uni_vacated_space); end
    n_chk++; if ({car_entered, car_exited, is_uni_car_entered, is_uni_car_exited} !== 4'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0000", {car_entered, car_exited, is_uni_car_entered, is_uni_car_exited}); end
    n_chk++; if ({gif.ent_gnt, gif.ent_deny, gif.ext_gnt, gif.ext_deny} !== 8'h00) begin
      n_fail++; $display("FAIL reset_resp: got %b want 00000000", {gif.ent_gnt, gif.ent_deny, gif.ext_gnt, gif.ext_deny}); end
    n_chk++; if ({parked_car, uni_parked_car} !== 20'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", parked_car, uni_parked_car); end
    n_chk++; if ({free_full, uni_full} !== 2'b00) begin n_fail++; $display("FAIL reset_full: got %b want 00", {free_full, uni_full}); end
    n_chk++; if ({deny_cnt_uni, deny_cnt_free} !== 32'd0) begin n_fail++; $display("FAIL reset_deny_cnt: got %0d/%0d want 0/0", deny_cnt_uni, deny_cnt_free); end
    rst = 1'b0;
  endtask

  task automatic test_exit_deny();
    int lat; logic [7:0] resp; logic [3:0] st; logic [1:0] hold;
    post(1'b0, 0, 1'b0);
    await_resp(8, lat, resp, st, hold);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL exit_deny_lat: got %0d want 1", lat); end
    n_chk++; if (resp !== 8'h01) begin n_fail++; $display("FAIL exit_deny_resp: got %b want 00000001", resp); end
    n_chk++; if (st[2] !== 1'b0) begin n_fail++; $display("FAIL exit_deny_strobe: got %b want 0", st[2]); end
    n_chk++; if (parked_car !== 10'd0) begin n_fail++; $display("FAIL exit_deny_count: got %0d want 0", parked_car); end
    // The next decision is allowed two cycles after the previous one.
    post(1'b0, 1, 1'b1);
    await_resp(8, lat, resp, st, hold);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL exit_deny2_lat: got %0d want 1", lat); end
    n_chk++; if (resp !== 8'h02) begin n_fail++; $display("FAIL exit_deny2_resp: got %b want 00000010", resp); end
    n_chk++; if (uni_parked_car !== 10'd0) begin n_fail++; $display("FAIL exit_deny2_count: got %0d want 0", uni_parked_car); end
    n_chk++; if (deny_cnt_free !== 16'd0) begin n_fail++; $display("FAIL exit_deny_stats: got %0d want 0", deny_cnt_free); end
  endtask

  task automatic test_fill_free();
    int lat; logic [7:0] resp; logic [3:0] st; logic [1:0] hold;
    for (int i = 0; i < 200; i++) begin
      post(1'b1, 0, 1'b0);
      await_resp(8, lat, resp, st, hold);
      n_chk++; if (lat !== ((i == 0) ? 1 : 2)) begin n_fail++; $display("FAIL fill_lat[%0d]: got %0d want %0d", i, lat, (i == 0) ? 1 : 2); end
      n_chk++; if (resp !== 8'h40 || st !== 4'b1000) begin n_fail++; $display("FAIL fill_resp[%0d]: got %b/%b want 01000000/1000", i, resp, st); end
      n_chk++; if (parked_car !== 10'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, parked_car, i + 1); end
    end
    n_chk++; if (vacated_space !== 10'd0 || free_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0d/%b want 0/1", vacated_space, free_full); end
    post(1'b1, 0, 1'b0);
    await_resp(8, lat, resp, st, hold);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL fill_deny_lat: got %0d want 2", lat); end
    n_chk++; if (resp !== 8'h10) begin n_fail++; $display("FAIL fill_deny_resp: got %b want 00010000", resp); end
    n_chk++; if (st[3] !== 1'b0) begin n_fail++; $display("FAIL fill_deny_strobe: got %b want 0", st[3]); end
    n_chk++; if (parked_car !== 10'd200) begin n_fail++; $display("FAIL fill_deny_count: got %0d want 200", parked_car); end
    n_chk++; if (deny_cnt_free !== (STATS ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL fill_deny_stats: got %0d want %0d", deny_cnt_free, STATS ? 1 : 0); end
  endtask

  task automatic test_priority();
    int lat; logic [7:0] resp; logic [3:0] st; logic [1:0] hold;
    for (int i = 0; i < 5; i++) begin
      post(1'b1, 1, 1'b1);
      await_resp(8, lat, resp, st, hold);
      n_chk++; if (resp !== 8'h80 || st !== 4'b1010) begin n_fail++; $display("FAIL prio_prefill[%0d]: got %b/%b want 10000000/1010", i, resp, st); end
    end
    n_chk++; if (uni_parked_car !== 10'd5) begin n_fail++; $display("FAIL prio_prefill_count: got %0d want 5", uni_parked_car); end
    @(negedge clk);
    gif.ent_req = 2'b11; gif.ent_uni = 2'b11; gif.ext_req[1] = 1'b1; gif.ext_uni[1] = 1'b1;
    await_resp(8, lat, resp, st, hold);
    n_chk++; if (lat !== 2 || resp !== 8'h08 || st !== 4'b0101) begin
      n_fail++; $display("FAIL prio_exit_first: got lat %0d %b/%b want lat 2 00001000/0101", lat, resp, st); end
    n_chk++; if (uni_parked_car !== 10'd4) begin n_fail++; $display("FAIL prio_exit_count: got %0d want 4", uni_parked_car); end
    await_resp(8, lat, resp, st, hold);
    n_chk++; if (hold !== 2'b01) begin n_fail++; $display("FAIL prio_exit_flag_hold: got %b want 01", hold); end
    n_chk++; if (lat !== 3 || resp !== 8'h40 || st !== 4'b1010) begin
      n_fail++; $display("FAIL prio_ent_gate0: got lat %0d %b/%b want lat 3 01000000/1010", lat, resp, st); end
    await_resp(8, lat, resp, st, hold);
    n_chk++; if (hold !== 2'b10) begin n_fail++; $display("FAIL prio_ent_flag_hold: got %b want 10", hold); end
    n_chk++; if (lat !== 3 || resp !== 8'h80 || st !== 4'b1010) begin
      n_fail++; $display("FAIL prio_ent_gate1: got lat %0d %b/%b want lat 3 10000000/1010", lat, resp, st); end
    n_chk++; if (uni_parked_car !== 10'd6) begin n_fail++; $display("FAIL prio_final_count: got %0d want 6", uni_parked_car); end
    await_resp(4, lat, resp, st, hold);
    n_chk++; if (lat !== -1) begin n_fail++; $display("FAIL prio_no_repeat: got response %b want none", resp); end
  endtask

  task automatic test_hour_sweep();
    int lat; logic [7:0] resp; logic [3:0] st; logic [1:0] hold;
    int exp_v[5] = '{0, 50, 100, 150, 300};
    for (int i = 0; i < 294; i++) begin
      post(1'b1, 0, 1'b1);
      await_resp(8, lat, resp, st, hold);
      n_chk++; if (resp !== 8'h40) begin n_fail++; $display("FAIL sweep_prefill[%0d]: got %b want 01000000", i, resp); end
    end
    n_chk++; if (uni_parked_car !== 10'd300) begin n_fail++; $display("FAIL sweep_prefill_count: got %0d want 300", uni_parked_car); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      hour = 5'(12 + k);
      #1;
      n_chk++; if (vacated_space !== 10'(exp_v[k])) begin n_fail++; $display("FAIL sweep_vacated[h%0d]: got %0d want %0d", 12 + k, vacated_space, exp_v[k]); end
    end
    n_chk++; if (uni_vacated_space !== 10'd0 || uni_full !== 1'b1) begin n_fail++; $display("FAIL sweep_uni_full: got %0d/%b want 0/1", uni_vacated_space, uni_full); end
    post(1'b1, 1, 1'b1);
    await_resp(8, lat, resp, st, hold);
    n_chk++; if (lat !== 1 || resp !== 8'h20 || st[3] !== 1'b0) begin
      n_fail++; $display("FAIL sweep_uni_deny: got lat %0d %b/%b want lat 1 00100000/0xxx", lat, resp, st); end
    n_chk++; if (uni_parked_car !== 10'd300) begin n_fail++; $display("FAIL sweep_uni_no_evict: got %0d want 300", uni_parked_car); end
    n_chk++; if (deny_cnt_uni !== (STATS ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL sweep_uni_stats: got %0d want %0d", deny_cnt_uni, STATS ? 1 : 0); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] resp; logic [3:0] st; logic [1:0] hold;
    hour = 5'd12;
    for (int i = 0; i < 2; i++) begin
      post(1'b1, 0, 1'b0);
      await_resp(8, lat, resp, st, hold);
      n_chk++; if (lat !== 1 || resp !== 8'h10) begin n_fail++; $display("FAIL rmid_deny[%0d]: got lat %0d %b want lat 1 00010000", i, lat, resp); end
    end
    n_chk++; if (deny_cnt_free !== (STATS ? 16'd3 : 16'd0)) begin n_fail++; $display("FAIL rmid_stats_before: got %0d want %0d", deny_cnt_free, STATS ? 3 : 0); end
    hour = 5'd9;
    post(1'b1, 1, 1'b1);
    await_resp(8, lat, resp, st, hold);
    n_chk++; if (resp !== 8'h80 || st !== 4'b1010) begin n_fail++; $display("FAIL rmid_grant: got %b/%b want 10000000/1010", resp, st); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({car_entered, car_exited, is_uni_car_entered, is_uni_car_exited} !== 4'b0) begin
      n_fail++; $display("FAIL rmid_strobes: got %b want 0000", {car_entered, car_exited, is_uni_car_entered, is_uni_car_exited}); end
    n_chk++; if ({parked_car, uni_parked_car} !== 20'd0) begin n_fail++; $display("FAIL rmid_counts: got %0d/%0d want 0/0", parked_car, uni_parked_car); end
    n_chk++; if ({deny_cnt_uni, deny_cnt_free} !== 32'd0) begin n_fail++; $display("FAIL rmid_stats_after: got %0d/%0d want 0/0", deny_cnt_uni, deny_cnt_free); end
    rst = 1'b0;
    post(1'b1, 0, 1'b0);
    await_resp(8, lat, resp, st, hold);
    n_chk++; if (lat !== 1 || resp !== 8'h40) begin n_fail++; $display("FAIL rmid_idle_after: got lat %0d %b want lat 1 01000000", lat, resp); end
    n_chk++; if (parked_car !== 10'd1 || vacated_space !== 10'd199) begin n_fail++; $display("FAIL rmid_recount: got %0d/%0d want 1/199", parked_car, vacated_space); end
  endtask

  task automatic test_random();
    int m_free, m_uni, m_dn_free, m_dn_uni, last_ent, last_ext;
    int lat, exp_lat, g, fc, pos, exp_vf, exp_vu;
    logic [1:0] pe, px, eu, xu, hold, prev_flags;
    logic [7:0] resp, exp_resp;
    logic [3:0] st, exp_st;
    bit first, prev_grant, is_exit, cls, ok;
    @(negedge clk);
    rst = 1'b1;
    gif.ent_req = '0; gif.ext_req = '0;
    @(negedge clk);
    rst = 1'b0;
    m_free = 0; m_uni = 0; m_dn_free = 0; m_dn_uni = 0;
    last_ent = 1; last_ext = 1;
    prev_flags = '0; prev_grant = 1'b0;
    for (int b = 0; b < 400; b++) begin
      repeat (2) @(negedge clk);
      hour = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      pe = 2'($urandom);
      px = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      if (pe == 2'b00 && px == 2'b00) pe = 2'b01;
      eu = 2'($urandom); xu = 2'($urandom);
      gif.ent_req = pe; gif.ent_uni = eu; gif.ext_req = px; gif.ext_uni = xu;
      first = 1'b1;
      while (pe != 2'b00 || px != 2'b00) begin
        fc = free_cap_of(int'(hour));
        is_exit = (px != 2'b00);
        if (is_exit) begin
          g = px[1 - last_ext] ? 1 - last_ext : last_ext;
          cls = xu[g];
          ok = cls ? (m_uni > 0) : (m_free > 0);
          if (ok) begin if (cls) m_uni--; else m_free--; end
          pos = ok ? 2 + g : g;
          px[g] = 1'b0; last_ext = g;
        end else begin
          g = pe[1 - last_ent] ? 1 - last_ent : last_ent;
          cls = eu[g];
          ok = cls ? (m_uni < 700 - fc) : (m_free < fc);
          if (ok) begin if (cls) m_uni++; else m_free++; end
          else begin if (cls) m_dn_uni++; else m_dn_free++; end
          pos = ok ? 6 + g : 4 + g;
          pe[g] = 1'b0; last_ent = g;
        end
        exp_resp = 8'd1 << pos;
        exp_st   = {!is_exit && ok, is_exit && ok, !is_exit && ok && cls, is_exit && ok && cls};
        exp_lat  = first ? 1 : (prev_grant ? 3 : 2);
        exp_vf   = (fc > m_free) ? fc - m_free : 0;
        exp_vu   = (700 - fc > m_uni) ? 700 - fc - m_uni : 0;
        await_resp(8, lat, resp, st, hold);
        n_chk++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_lat[b%0d]: got %0d want %0d", b, lat, exp_lat); end
        n_chk++; if (resp !== exp_resp || st !== exp_st) begin n_fail++; $display("FAIL rnd_resp[b%0d]: got %b/%b want %b/%b", b, resp, st, exp_resp, exp_st); end
        n_chk++; if (parked_car !== 10'(m_free) || uni_parked_car !== 10'(m_uni)) begin
          n_fail++; $display("FAIL rnd_counts[b%0d]: got %0d/%0d want %0d/%0d", b, parked_car, uni_parked_car, m_free, m_uni); end
        n_chk++; if (vacated_space !== 10'(exp_vf) || uni_vacated_space !== 10'(exp_vu) || free_full !== (exp_vf == 0) || uni_full !== (exp_vu == 0)) begin
          n_fail++; $display("FAIL rnd_vacated[b%0d]: got %0d/%0d/%b%b want %0d/%0d", b, vacated_space, uni_vacated_space, free_full, uni_full, exp_vf, exp_vu); end
        if (!first && prev_grant) begin
          n_chk++; if (hold !== prev_flags) begin n_fail++; $display("FAIL rnd_flag_hold[b%0d]: got %b want %b", b, hold, prev_flags); end
        end
        prev_grant = ok; prev_flags = exp_st[1:0]; first = 1'b0;
      end
    end
    n_chk++; if (deny_cnt_free !== (STATS ? 16'(m_dn_free) : 16'd0) || deny_cnt_uni !== (STATS ? 16'(m_dn_uni) : 16'd0)) begin
      n_fail++; $display("FAIL rnd_stats: got %0d/%0d want %0d/%0d", deny_cnt_free, deny_cnt_uni, STATS ? m_dn_free : 0, STATS ? m_dn_uni : 0); end
  endtask

  initial begin
    test_reset();
    test_exit_deny();
    test_fill_free();
    test_priority();
    test_hour_sweep();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/park_gate_ctrl.md
# park_gate_ctrl

Synchronous gate controller for the parking datapath. Accepts entry and exit requests from two physical gates, arbitrates them one event at a time, and checks each entry against an hour-dependent capacity split between university and free spaces. Granted events are issued to the `park` occupancy core as clean single-cycle `car_entered` / `car_exited` pulses with the class flag held stable. The block keeps its own authoritative occupancy counters.

## Interface
- `TOTAL_CAP`, 700: total spaces (university + free); must be < 1024.
- `FREE_BASE`, 200: free-space capacity during hours 8..12.
- `FREE_STEP`, 50: free-capacity increase per hour from hour 13.
- `FREE_MAX`, 500: free capacity from hour 16 through hour 7, and for any hour > 23.
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `hour` in 5: hour of day, 0..23.
- `ent_req` in 2: per-gate entry request; held until that gate's `ent_gnt` or `ent_deny`.
- `ent_uni` in 2: per-gate entry class (1 = university); stable while the request is held.
- `ext_req` in 2: per-gate exit request.
- `ext_uni` in 2: per-gate exit class.
- `ent_gnt`, `ent_deny` out 2: one-cycle per-gate entry response.
- `ext_gnt`, `ext_deny` out 2: one-cycle per-gate exit response.
- `car_entered`, `car_exited` out 1: one-cycle strobes to the `park` core.
- `is_uni_car_entered`, `is_uni_car_exited` out 1: class flags; valid in the strobe cycle and the following cycle.
- `uni_parked_car`, `parked_car` out 10: current occupancy per class.
- `uni_vacated_space`, `vacated_space` out 10: remaining capacity per class, saturating at 0.
- `uni_full`, `free_full` out 1: high when the corresponding vacated count is 0.
- `deny_cnt_uni`, `deny_cnt_free` out 16: denied-entry statistics (see Configuration).

## Operation
- Capacity is a combinational function of the current `hour`:
  - `free_cap` = FREE_BASE for hours 8..12.
  - `free_cap` = FREE_BASE + FREE_STEP × (hour − 12) for hours 13..15.
  - `free_cap` = FREE_MAX for all other hours, including hour > 23.
  - `uni_cap` = TOTAL_CAP − `free_cap`.
- Vacated count per class is cap − parked, clamped at 0. When capacity shrinks below occupancy, the vacated count reads 0 and no eviction occurs.
- FSM states are IDLE, ISSUE and GAP.
  - Decisions are made only in IDLE when any request is pending.
  - Grant path: IDLE → ISSUE → GAP → IDLE.
  - Deny path: IDLE → GAP → IDLE.
- Priority: any exit beats any entry, because exits free space.
- Within each of the entry and exit classes, two-gate round-robin applies. The pointer advances past the served gate on both grant and deny.
- An entry is denied if its class vacated count is 0; otherwise it is granted and that class counter increments.
- An exit is denied if its class parked count is 0; otherwise it is granted and that class counter decrements.
- A deny produces no core strobe.
- `parked_car` counts free-class cars only. Total occupancy is `parked_car` + `uni_parked_car`.
- Requests arriving while in ISSUE or GAP wait; they are never dropped.

## Timing
- A decision made in IDLE cycle T takes effect at T+1:
  - the gnt or deny pulse is high for exactly cycle T+1;
  - for a grant, the core strobe is high in T+1 and `is_uni_*` is held through T+2;
  - counters, vacated counts and full flags reflect the event from T+1.
- Throughput: one grant per 3 cycles; one deny per 2 cycles.
- Requesters must drop `req` by the cycle after their response. GAP guarantees a request is never served twice.
- `hour` is sampled in the decision cycle only. A mid-sequence hour change affects the next decision.
- Reset values:
  - state IDLE; both round-robin pointers at gate 0;
  - all gnt, deny, strobe and class outputs 0;
  - both parked counts 0 and both deny counters 0;
  - vacated counts and full flags follow capacity immediately.
- Reset mid-sequence aborts any strobe in the following cycle. Occupancy is lost; the core must be reset together with this block.

## Configuration
- `PARK_CTRL_STATS_EN` defined: `deny_cnt_uni` / `deny_cnt_free` increment on each entry deny of that class, saturate at 16'hFFFF, and clear on reset.
- `PARK_CTRL_STATS_EN` undefined: both ports are tied to 0 and no counter registers exist.

## Test plan
- Reset, hour=9:
  - `vacated_space`=200, `uni_vacated_space`=500, all strobes 0.
  - Then 200 free entries from gate 0: each granted 3 cycles apart; 201st → `ent_deny`[0] at T+1, no `car_entered`, `free_full`=1.
- Simultaneous `ent_req`=2'b11, both uni, with `ext_req`[1] uni and `uni_parked_car`=5:
  - exit gate 1 granted first (count 4);
  - then entry gate 0, then entry gate 1;
  - strobes at cycles T+1, T+4, T+7.
- Exit of free class with `parked_car`=0 → `ext_deny` at T+1, counter stays 0, next decision possible at T+2.
- Hour 12→16 with 200 free parked:
  - `vacated_space` 0 → 50 → 100 → 150 → 300;
  - uni cap drops to 200 with 300 uni parked → `uni_vacated_space`=0, `uni_full`=1, uni entry denied.
- Assert `rst` in the ISSUE cycle:
  - next cycle all strobes 0, counts 0, state IDLE;
  - with `PARK_CTRL_STATS_EN`, 3 prior denies → `deny_cnt_free`=3 before reset, 0 after.
